// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundles are listed in the order
// {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble}.
package pipe_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_we;
      logic mem_wb_bubble;
   } ctrl_t;

   // Safe "nothing moves, nothing commits" pattern used in reset and ERR.
   localparam ctrl_t FREEZE_CTRL = 6'b001101;
   // Memory wait: whole front end holds, MEM_WB gets a bubble.
   localparam ctrl_t HOLD_CTRL   = 6'b000001;
   // Taken branch: kill IF_ID and ID instruction, redirect PC.
   localparam ctrl_t BRANCH_CTRL = 6'b111110;
   // Load-use: hold PC/IF_ID, insert one bubble into ID_EX.
   localparam ctrl_t STALL_CTRL  = 6'b000110;
   // Normal flow.
   localparam ctrl_t GO_CTRL     = 6'b110010;

   // Saturating 16-bit increment for the statistics counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags when the limit is reached.
// The counter saturates at MEM_TIMEOUT-1 so it can never wrap.
module pipe_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_r;

   // Wait counter: clear has priority, then saturating increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (inc && (cnt_r != LAST_CNT)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == LAST_CNT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory waits
// and a sticky memory-timeout error. Controls are combinational from the
// FSM state and current inputs. Optional statistics counters are built when
// HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
   parameter int REG_W       = pipe_pkg::REG_W,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_we,
   output logic             mem_wb_bubble,
   output logic             timeout_err,
   output logic [1:0]       state
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]      stall_cnt,
   output logic [15:0]      flush_cnt,
   output logic [15:0]      wait_cnt
`endif
);

   import pipe_pkg::*;

   state_t state_r;
   state_t state_nxt_s;
   ctrl_t  ctrl_s;
   logic   load_use_s;
   logic   hold_s;
   logic   expired_s;
   logic   timeout_err_r;
   logic   is_stall_s;
   logic   is_flush_s;
   logic   is_wait_s;

   // Register 0 is hard-wired, so a load targeting it never stalls.
   assign load_use_s = ex_mem_read && (ex_rt != REG_W'(ZERO_REG)) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Memory still busy: either already waiting or a fresh access not done.
   assign hold_s = !mem_ready && ((state_r == MEM_WAIT) || mem_req);

   pipe_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_r != MEM_WAIT),
      .inc     (state_r == MEM_WAIT),
      .expired (expired_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_nxt_s = MEM_WAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt_s = RUN;
            end else if (expired_s) begin
               state_nxt_s = ERR;
            end else begin
               state_nxt_s = MEM_WAIT;
            end
         end
         ERR: begin
            state_nxt_s = ERR;
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // Pipeline controls, priority ERR > memory wait > branch > load-use.
   always_comb begin
      ctrl_s     = GO_CTRL;
      is_stall_s = 1'b0;
      is_flush_s = 1'b0;
      is_wait_s  = 1'b0;
      if (!rst_n) begin
         ctrl_s = FREEZE_CTRL;
      end else if (state_r == ERR) begin
         ctrl_s = FREEZE_CTRL;
      end else if (hold_s) begin
         ctrl_s    = HOLD_CTRL;
         is_wait_s = 1'b1;
      end else if (ex_branch_taken) begin
         ctrl_s     = BRANCH_CTRL;
         is_flush_s = 1'b1;
      end else if (load_use_s) begin
         ctrl_s     = STALL_CTRL;
         is_stall_s = 1'b1;
      end else begin
         ctrl_s = GO_CTRL;
      end
   end

   // Sticky timeout flag, raised together with the transition into ERR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err_r <= 1'b0;
      end else if ((state_r == MEM_WAIT) && !mem_ready && expired_s) begin
         timeout_err_r <= 1'b1;
      end else begin
         timeout_err_r <= timeout_err_r;
      end
   end

   assign pc_we         = ctrl_s.pc_we;
   assign if_id_we      = ctrl_s.if_id_we;
   assign if_id_flush   = ctrl_s.if_id_flush;
   assign id_ex_bubble  = ctrl_s.id_ex_bubble;
   assign ex_mem_we     = ctrl_s.ex_mem_we;
   assign mem_wb_bubble = ctrl_s.mem_wb_bubble;
   assign timeout_err   = timeout_err_r;
   assign state         = state_r;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_r;
   logic [15:0] flush_cnt_r;
   logic [15:0] wait_cnt_r;

   // Saturating event counters for load-use bubbles, flushes and wait cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 16'd0;
         flush_cnt_r <= 16'd0;
         wait_cnt_r  <= 16'd0;
      end else begin
         stall_cnt_r <= is_stall_s ? sat_inc16(stall_cnt_r) : stall_cnt_r;
         flush_cnt_r <= is_flush_s ? sat_inc16(flush_cnt_r) : flush_cnt_r;
         wait_cnt_r  <= is_wait_s  ? sat_inc16(wait_cnt_r)  : wait_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
   assign wait_cnt  = wait_cnt_r;
`else
   logic unused_stats_s;
   assign unused_stats_s = is_stall_s ^ is_flush_s ^ is_wait_s;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues directed and random
// stimulus and pushes the model's expected response; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

   localparam int REG_W       = 5;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [REG_W-1:0] id_rs, id_rt, ex_rt;
   logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
   logic             pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble;
   logic             timeout_err;
   logic [1:0]       state;
`ifdef HAZARD_STATS_EN
   logic [15:0]      stall_cnt, flush_cnt, wait_cnt;
`endif

   pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
      .mem_wb_bubble(mem_wb_bubble), .timeout_err(timeout_err), .state(state)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
   );

   typedef struct {
      logic [5:0] ctrl;
      logic [1:0] st;
      logic       terr;
      int         sc;
      int         fc;
      int         wc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: "stuck" flags and a count of memory-wait cycles.
   bit m_err;
   bit m_waiting;
   int m_waited;
   int m_sc, m_fc, m_wc;

   // Expected control patterns {pc_we,if_id_we,if_id_flush,id_ex_bubble,ex_mem_we,mem_wb_bubble}
   localparam logic [5:0] E_FREEZE = 6'b001101;
   localparam logic [5:0] E_HOLD   = 6'b000001;
   localparam logic [5:0] E_BRANCH = 6'b111110;
   localparam logic [5:0] E_STALL  = 6'b000110;
   localparam logic [5:0] E_GO     = 6'b110010;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic set_idle();
      rst_n = 1'b1; id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic rand_inputs();
      rst_n           = ($urandom_range(0, 59) != 0);
      id_rs           = REG_W'($urandom_range(0, 3));
      id_rt           = REG_W'($urandom_range(0, 3));
      ex_rt           = REG_W'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 1) == 1);
   endtask

   // Apply current inputs: predict response, push it, advance the model, clock.
   task automatic tick();
      exp_t e;
      bit   lu;
      bit   busy;
      lu   = ex_mem_read && (int'(ex_rt) != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      busy = !mem_ready && (m_waiting || mem_req);
      if (!rst_n) begin
         m_err = 0; m_waiting = 0; m_waited = 0; m_sc = 0; m_fc = 0; m_wc = 0;
         e.ctrl = E_FREEZE; e.st = 2'd0; e.terr = 1'b0; e.sc = 0; e.fc = 0; e.wc = 0;
      end else begin
         e.st   = m_err ? 2'd2 : (m_waiting ? 2'd1 : 2'd0);
         e.terr = m_err;
         e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
         if (m_err) begin
            e.ctrl = E_FREEZE;
         end else if (busy) begin
            e.ctrl = E_HOLD;   m_wc = (m_wc < 65535) ? m_wc + 1 : m_wc;
         end else if (ex_branch_taken) begin
            e.ctrl = E_BRANCH; m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
         end else if (lu) begin
            e.ctrl = E_STALL;  m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
         end else begin
            e.ctrl = E_GO;
         end
         if (!m_err) begin
            if (m_waiting) begin
               if (mem_ready) begin
                  m_waiting = 0;
               end else if (m_waited + 1 == MEM_TIMEOUT) begin
                  m_err = 1; m_waiting = 0;
               end else begin
                  m_waited++;
               end
            end else if (mem_req && !mem_ready) begin
               m_waiting = 1; m_waited = 0;
            end
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("ctrl", 32'({pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble}), 32'(e.ctrl));
         chk("state", 32'(state), 32'(e.st));
         chk("timeout_err", 32'(timeout_err), 32'(e.terr));
`ifdef HAZARD_STATS_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
         chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
         chk("wait_cnt", 32'(wait_cnt), 32'(e.wc));
`endif
      end
   end

   initial begin
      set_idle();
      rst_n = 1'b0;
      m_err = 0; m_waiting = 0; m_waited = 0; m_sc = 0; m_fc = 0; m_wc = 0;
      @(posedge clk);
      #1;
      // Reset held with random inputs
      repeat (4) begin
         rand_inputs(); rst_n = 1'b0; tick();
      end
      set_idle(); tick(); tick();
      // Load-use on rs, then the bubble clears the hazard
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; tick();
      ex_mem_read = 1'b0; tick();
      // Load-use on rt
      set_idle(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd2; id_rt = 5'd5; id_uses_rt = 1'b1; tick();
      ex_mem_read = 1'b0; tick();
      // Register 0 never stalls
      set_idle(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; tick();
      // Branch with load-use in the same cycle
      set_idle(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1; tick();
      set_idle(); tick();
      // Memory wait of three cycles, completion with a branch pending
      mem_req = 1'b1; mem_ready = 1'b0; repeat (3) tick();
      mem_ready = 1'b1; ex_branch_taken = 1'b1; tick();
      set_idle(); tick(); tick();
      // Memory timeout, then mem_ready must not clear the error
      mem_req = 1'b1; mem_ready = 1'b0; repeat (6) tick();
      mem_ready = 1'b1; repeat (2) tick();
      rst_n = 1'b0; tick();
      set_idle(); tick();
      // Reset in the middle of a wait
      mem_req = 1'b1; mem_ready = 1'b0; repeat (2) tick();
      rst_n = 1'b0; tick();
      set_idle(); repeat (2) tick();
      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         rand_inputs(); tick();
      end
      set_idle(); tick();
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
